gpio_irq_ctrl: RTL and testbench

// - Input-side companion to the 8-bit GPIO: consumes raw pin levels and produces the GPIO interrupt.
// - Per pin: synchronise, debounce, detect rising/falling edges, latch pending bits, raise irq.
// - Memory-mapped slave on slave_bus_if; irq feeds the platform interrupt controller.

---
 rtl/gpio_pkg.sv | 33 +++
 rtl/slave_bus_if.sv | 12 +
 rtl/gpio_debounce_bit.sv | 41 ++++
 rtl/gpio_irq_ctrl.sv | 96 +++++++++
 tb/tb_gpio_irq_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO interrupt controller: register offsets,
// pin limit and the bus address decoder.
package gpio_pkg;

  localparam int GPIO_MAX_PINS = 32;

  localparam logic [7:0] GPIO_IRQ_STATE = 8'h00;
  localparam logic [7:0] GPIO_IRQ_RISE  = 8'h04;
  localparam logic [7:0] GPIO_IRQ_FALL  = 8'h08;
  localparam logic [7:0] GPIO_IRQ_PEND  = 8'h0C;
  localparam logic [7:0] GPIO_IRQ_DEB   = 8'h10;

  typedef enum logic [2:0] {
    REG_STATE,
    REG_RISE,
    REG_FALL,
    REG_PEND,
    REG_DEB,
    REG_NONE
  } gpio_reg_e;

  function automatic gpio_reg_e decode_addr(input logic [7:0] addr);
    case (addr)
      GPIO_IRQ_STATE: decode_addr = REG_STATE;
      GPIO_IRQ_RISE:  decode_addr = REG_RISE;
      GPIO_IRQ_FALL:  decode_addr = REG_FALL;
      GPIO_IRQ_PEND:  decode_addr = REG_PEND;
      GPIO_IRQ_DEB:   decode_addr = REG_DEB;
      default:        decode_addr = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/slave_bus_if.sv
// Simple single-cycle memory-mapped bus shared by the platform peripherals.
interface slave_bus_if;
  logic        ss;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        bdone;

  modport slave  (input ss, we, addr, wdata, output rdata, bdone);
  modport master (output ss, we, addr, wdata, input rdata, bdone);
endinterface

// File: rtl/gpio_debounce_bit.sv
// One pin's synchroniser, debounce counter and debounced level flop.
module gpio_debounce_bit #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [CNT_W-1:0] deb,
  input  logic             deb_wr,
  output logic             stable
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   sync_in;

  assign sync_in = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      // A new threshold restarts every count but keeps the current level.
      if (deb_wr) begin
        cnt <= '0;
      end else if (sync_in == stable) begin
        cnt <= '0;
      end else if (cnt == deb) begin
        stable <= sync_in;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO input interrupt controller: debounced pin levels, edge detection,
// W1C pending register and a level interrupt on the slave bus.
module gpio_irq_ctrl #(
  parameter int N_PINS      = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  slave_bus_if.slave        bus,
  input  logic [N_PINS-1:0] pins_in,
  output logic              irq
);
  import gpio_pkg::*;

  gpio_reg_e         sel;
  logic              wr;
  logic              deb_wr;
  logic [N_PINS-1:0] stable;
  logic [N_PINS-1:0] stable_q;
  logic [N_PINS-1:0] rise_en;
  logic [N_PINS-1:0] fall_en;
  logic [N_PINS-1:0] pending;
  logic [N_PINS-1:0] pending_next;
  logic [N_PINS-1:0] rise;
  logic [N_PINS-1:0] fall;
  logic [N_PINS-1:0] clr;
  logic [CNT_W-1:0]  deb;
  logic [31:0]       rdata;
  logic              unused_wdata;

  assign sel          = decode_addr(bus.addr);
  assign wr           = bus.ss && bus.we;
  assign deb_wr       = wr && (sel == REG_DEB);
  assign unused_wdata = ^bus.wdata;

  for (genvar i = 0; i < N_PINS; i++) begin : g_pin
    gpio_debounce_bit #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (pins_in[i]),
      .deb    (deb),
      .deb_wr (deb_wr),
      .stable (stable[i])
    );
  end

  assign rise = stable & ~stable_q;
  assign fall = ~stable & stable_q;
  assign clr  = (wr && (sel == REG_PEND)) ? bus.wdata[N_PINS-1:0] : '0;

  // Newly detected edges are ORed in after the clear so a set always wins.
  assign pending_next = (pending & ~clr) | (rise & rise_en) | (fall & fall_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      pending  <= '0;
      irq      <= 1'b0;
      rise_en  <= '0;
      fall_en  <= '0;
      deb      <= '0;
    end else begin
      stable_q <= stable;
      pending  <= pending_next;
      irq      <= |pending_next;
      if (wr) begin
        case (sel)
          REG_RISE: rise_en <= bus.wdata[N_PINS-1:0];
          REG_FALL: fall_en <= bus.wdata[N_PINS-1:0];
          REG_DEB:  deb     <= bus.wdata[CNT_W-1:0];
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      REG_STATE: rdata[N_PINS-1:0] = stable;
      REG_RISE:  rdata[N_PINS-1:0] = rise_en;
      REG_FALL:  rdata[N_PINS-1:0] = fall_en;
      REG_PEND:  rdata[N_PINS-1:0] = pending;
      REG_DEB:   rdata[CNT_W-1:0]  = deb;
      default:   rdata = '0;
    endcase
  end

  assign bus.rdata = rdata;
  assign bus.bdone = 1'b1;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Scoreboard bench for gpio_irq_ctrl: directed pin/bus sequences push expected
// register reads; a negedge monitor pops and compares every read the bus presents.
module tb_gpio_irq_ctrl;

  localparam logic [7:0] A_STATE = 8'h00;
  localparam logic [7:0] A_RISE  = 8'h04;
  localparam logic [7:0] A_FALL  = 8'h08;
  localparam logic [7:0] A_PEND  = 8'h0C;
  localparam logic [7:0] A_DEB   = 8'h10;
  localparam logic [7:0] A_BAD   = 8'h14;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        irq;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] pins_in;
  logic       irq;
  exp_t       sb_q[$];
  int         n_cmp;
  int         n_err;

  slave_bus_if bus_i ();

  gpio_irq_ctrl #(
    .N_PINS      (8),
    .CNT_W       (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_i.slave),
    .pins_in (pins_in),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s.%s actual=0x%08h required=0x%08h", name, field, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    bus_i.ss    = 1'b1;
    bus_i.we    = 1'b1;
    bus_i.addr  = addr;
    bus_i.wdata = data;
    tick();
    bus_i.ss    = 1'b0;
    bus_i.we    = 1'b0;
  endtask

  // Queue the expectation, then present the read for one cycle.
  task automatic apply_stimulus(input string name, input logic [7:0] addr,
                                input logic [31:0] exp_rdata, input logic exp_irq);
    exp_t e;
    e.name  = name;
    e.rdata = exp_rdata;
    e.irq   = exp_irq;
    sb_q.push_back(e);
    bus_i.ss   = 1'b1;
    bus_i.we   = 1'b0;
    bus_i.addr = addr;
    tick();
    bus_i.ss   = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_i.ss && !bus_i.we) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("[TB] FAIL unexpected_read addr=0x%02h actual=0x%08h required=none",
                   bus_i.addr, bus_i.rdata);
        end else begin
          e = sb_q.pop_front();
          check_output(e.name, "rdata", bus_i.rdata, e.rdata);
          check_output(e.name, "irq", {31'b0, irq}, {31'b0, e.irq});
          check_output(e.name, "bdone", {31'b0, bus_i.bdone}, 32'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    pins_in     = 8'h00;
    bus_i.ss    = 1'b0;
    bus_i.we    = 1'b0;
    bus_i.addr  = 8'h00;
    bus_i.wdata = 32'h0;

    // Power-on reset
    repeat (2) tick();
    apply_stimulus("por_state", A_STATE, 32'h0, 1'b0);
    apply_stimulus("por_rise",  A_RISE,  32'h0, 1'b0);
    apply_stimulus("por_pend",  A_PEND,  32'h0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    apply_stimulus("rst_fall", A_FALL, 32'h0, 1'b0);
    apply_stimulus("rst_deb",  A_DEB,  32'h0, 1'b0);

    // DEB=0 rising edge on pin0: pending at k+3, cleared by W1C
    bus_write(A_RISE, 32'h01);
    pins_in = 8'h01;
    repeat (3) tick();
    apply_stimulus("rise0_k2",  A_PEND, 32'h00, 1'b0);
    apply_stimulus("rise0_k3",  A_PEND, 32'h01, 1'b1);
    bus_write(A_PEND, 32'h01);
    apply_stimulus("rise0_w1c", A_PEND, 32'h00, 1'b0);

    // DEB=4 falling edge on pin7: short glitch dropped, long low latched at k+7
    bus_write(A_DEB, 32'h4);
    pins_in = 8'h81;
    repeat (12) tick();
    apply_stimulus("p7_high_state", A_STATE, 32'h81, 1'b0);
    apply_stimulus("p7_high_pend",  A_PEND,  32'h00, 1'b0);
    bus_write(A_FALL, 32'h80);
    pins_in = 8'h01;
    repeat (3) tick();
    pins_in = 8'h81;
    repeat (10) tick();
    apply_stimulus("glitch_pend",  A_PEND,  32'h00, 1'b0);
    apply_stimulus("glitch_state", A_STATE, 32'h81, 1'b0);
    pins_in = 8'h01;
    repeat (7) tick();
    apply_stimulus("fall7_k6", A_PEND, 32'h00, 1'b0);
    apply_stimulus("fall7_k7", A_PEND, 32'h80, 1'b1);
    bus_write(A_PEND, 32'h80);
    apply_stimulus("fall7_w1c", A_PEND, 32'h00, 1'b0);

    // Simultaneous W1C and new rise on pin2: set wins
    bus_write(A_DEB, 32'h0);
    bus_write(A_RISE, 32'h04);
    pins_in = 8'h05;
    repeat (5) tick();
    apply_stimulus("p2_first", A_PEND, 32'h04, 1'b1);
    pins_in = 8'h01;
    repeat (5) tick();
    apply_stimulus("p2_fall_masked", A_PEND, 32'h04, 1'b1);
    pins_in = 8'h05;
    repeat (3) tick();
    bus_write(A_PEND, 32'h04);
    apply_stimulus("set_wins", A_PEND, 32'h04, 1'b1);
    bus_write(A_PEND, 32'h04);
    apply_stimulus("p2_w1c", A_PEND, 32'h00, 1'b0);

    // All edges enabled, 0x00 -> 0xA5 -> 0x00, plus unmapped address
    pins_in = 8'h00;
    repeat (5) tick();
    bus_write(A_PEND, 32'hFF);
    bus_write(A_RISE, 32'hFF);
    bus_write(A_FALL, 32'hFF);
    apply_stimulus("all_clean", A_PEND, 32'h00, 1'b0);
    pins_in = 8'hA5;
    repeat (5) tick();
    apply_stimulus("a5_state", A_STATE, 32'hA5, 1'b1);
    pins_in = 8'h00;
    repeat (5) tick();
    apply_stimulus("a5_pend",  A_PEND,  32'hA5, 1'b1);
    apply_stimulus("a5_state0", A_STATE, 32'h00, 1'b1);
    apply_stimulus("unmapped_rd", A_BAD, 32'h0, 1'b1);
    bus_write(A_BAD, 32'hFFFF_FFFF);
    apply_stimulus("unmapped_rise", A_RISE, 32'hFF, 1'b1);
    apply_stimulus("unmapped_fall", A_FALL, 32'hFF, 1'b1);
    apply_stimulus("unmapped_deb",  A_DEB,  32'h00, 1'b1);
    apply_stimulus("unmapped_pend", A_PEND, 32'hA5, 1'b1);

    // DEBOUNCE rewritten 8 -> 2 while pin3 count is 5: count restarts
    bus_write(A_PEND, 32'hFF);
    bus_write(A_FALL, 32'h00);
    bus_write(A_RISE, 32'h08);
    bus_write(A_DEB, 32'h8);
    apply_stimulus("deb_clean", A_PEND, 32'h00, 1'b0);
    pins_in = 8'h08;
    repeat (7) tick();
    bus_write(A_DEB, 32'h2);
    repeat (2) tick();
    apply_stimulus("deb_w2",    A_STATE, 32'h00, 1'b0);
    apply_stimulus("deb_w3",    A_STATE, 32'h08, 1'b0);
    apply_stimulus("deb_pend",  A_PEND,  32'h08, 1'b1);
    apply_stimulus("deb_value", A_DEB,   32'h02, 1'b1);

    // Reset mid-count, then a pin held high at release rises only if enabled
    bus_write(A_PEND, 32'hFF);
    bus_write(A_RISE, 32'hFF);
    pins_in = 8'h5A;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    apply_stimulus("mid_rst_state", A_STATE, 32'h0, 1'b0);
    apply_stimulus("mid_rst_rise",  A_RISE,  32'h0, 1'b0);
    apply_stimulus("mid_rst_pend",  A_PEND,  32'h0, 1'b0);
    apply_stimulus("mid_rst_deb",   A_DEB,   32'h0, 1'b0);
    #2 rst_n = 1'b1;
    bus_write(A_RISE, 32'h02);
    repeat (4) tick();
    apply_stimulus("post_rst_pend",  A_PEND,  32'h02, 1'b1);
    apply_stimulus("post_rst_state", A_STATE, 32'h5A, 1'b1);

    for (int i = 0; i < 5 && sb_q.size() != 0; i++) tick();
    if (sb_q.size() != 0) begin
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
      n_cmp += sb_q.size();
      n_err += sb_q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
